stall_ctrl: RTL and testbench
=============================

STALL_CTRL -- requirements
Module: stall_ctrl

Interface
REQ-001 Parameter FLUSH_CYCLES, default 1, range 1-7: number of consecutive cycles IF_ID_Flush SHALL assert per taken branch.
REQ-002 Parameter CNT_W, default 8: width of Stall_Count.
REQ-003 CLK  input  1  clock; all state SHALL update on the rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 ID_Rs  input  2  source register A of the instruction in ID.
REQ-006 ID_Rt  input  2  source register B of the instruction in ID.
REQ-007 ID_Uses_Rt  input  1  ID instruction reads ID_Rt.
REQ-008 EX_MemRead  input  1  EX instruction is a load.
REQ-009 EX_RegWrite  input  1  EX instruction writes EX_Rd.
REQ-010 EX_Rd  input  2  destination register of the EX instruction.
REQ-011 Branch_Taken  input  1  branch resolved taken in EX this cycle.
REQ-012 Mem_Busy  input  1  data memory not ready; the whole pipe must freeze.
REQ-013 Halt  input  1  HLT instruction reached EX.
REQ-014 PC_En, IF_ID_En, ID_EX_En, EX_MEM_En, MEM_WB_En  output  1 each  load enables for the PC and the pipeline registers.
REQ-015 IF_ID_Flush, ID_EX_Flush  output  1 each  synchronous clear, converting the stage to a bubble.
REQ-016 State  output  2  FSM state: RUN=00, FLUSH=01, MEM_WAIT=10, HALTED=11.
REQ-017 Stall_Count  output  CNT_W  saturating count of cycles with PC_En=0, excluding HALTED.

Function
REQ-018 Enables and flushes SHALL be combinational from State, the internal counters and the current inputs, with zero-cycle latency.
REQ-019 Load-use hazard (LU) SHALL be EX_MemRead & EX_RegWrite & (EX_Rd==ID_Rs | (ID_Uses_Rt & EX_Rd==ID_Rt)).
REQ-020 Priority in RUN and FLUSH SHALL be Mem_Busy > Halt > Branch_Taken > LU.
REQ-021 Mem_Busy in RUN or FLUSH: all enables 0 and both flushes 0 this cycle; next State=MEM_WAIT; the pre-wait state and the flush counter are saved.
REQ-022 MEM_WAIT:
- All enables 0 and flushes 0 while Mem_Busy=1.
- The first cycle with Mem_Busy=0 is evaluated as the saved state, with the counter unchanged, and State returns there at the next edge.
- Halt and Branch_Taken are ignored while Mem_Busy=1.
REQ-023 Halt, not preempted: PC_En=0 and IF_ID_En=0; ID_EX_En, EX_MEM_En and MEM_WB_En stay 1 to drain; next State=HALTED.
REQ-024 HALTED: all enables 0, flushes 0; exit only via RST.
REQ-025 Branch_Taken in RUN: all enables 1, IF_ID_Flush=1, ID_EX_Flush=1.
- FLUSH_CYCLES=1: remain in RUN.
- Otherwise: next State=FLUSH with counter=FLUSH_CYCLES-1.
REQ-026 FLUSH: all enables 1, IF_ID_Flush=1, ID_EX_Flush=0; counter decrements; at counter==1 the next State is RUN.
REQ-027 Branch_Taken in FLUSH SHALL reload counter=FLUSH_CYCLES-1 and assert both flushes.
REQ-028 LU with no higher-priority event: PC_En=0, IF_ID_En=0, ID_EX_Flush=1, other enables 1; single bubble, State unchanged.
REQ-029 LU SHALL be ignored in any cycle where Branch_Taken=1 or IF_ID_Flush=1, because the ID instruction is wrong-path.
REQ-030 Stall_Count SHALL increment on each edge where PC_En=0 and State!=HALTED, and hold at 2^CNT_W-1.

Reset
REQ-031 While RST=1: State=RUN, counters and saved state=0, Stall_Count=0, all enables 0, all flushes 0.
REQ-032 On the first edge after RST falls, outputs SHALL follow REQ-018..030 from RUN.
REQ-033 RST mid-MEM_WAIT or mid-FLUSH SHALL discard the saved state and the counter.

Verification
REQ-034 LU: EX_MemRead=1, EX_RegWrite=1, EX_Rd=2, ID_Rs=2 for one cycle -> PC_En=0, IF_ID_En=0, ID_EX_Flush=1 that cycle; Stall_Count 0->1; State stays 00.
REQ-035 FLUSH_CYCLES=3, Branch_Taken 1-cycle pulse in RUN:
- Cycle 0: both flushes.
- Cycles 1-2: State=01, IF_ID_Flush=1.
- Cycle 3: State=00.
- A concurrent LU produces no stall.
REQ-036 FLUSH_CYCLES=3: Mem_Busy raised for 4 cycles in the second FLUSH cycle -> enables 0 for 4 cycles, State=10, Stall_Count+4; flushing then resumes for the remaining cycles.
REQ-037 Halt and Branch_Taken in the same RUN cycle -> PC_En=0, IF_ID_En=0, no flush, State=11; Stall_Count frozen; only RST returns State to 00.
REQ-038 CNT_W=4, Mem_Busy held for 20 cycles -> Stall_Count saturates at 15; asserting RST mid-wait clears all outputs immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/stall_ctrl_if.sv
// ==== stall_ctrl_if: hazard inputs and pipeline enable/flush outputs of stall_ctrl ====
// ==== rev 1.0 ====
`default_nettype none

interface stall_ctrl_if #(
  parameter int CNT_W = 8
);
  logic [1:0]       ID_Rs;
  logic [1:0]       ID_Rt;
  logic             ID_Uses_Rt;
  logic             EX_MemRead;
  logic             EX_RegWrite;
  logic [1:0]       EX_Rd;
  logic             Branch_Taken;
  logic             Mem_Busy;
  logic             Halt;
  logic             PC_En;
  logic             IF_ID_En;
  logic             ID_EX_En;
  logic             EX_MEM_En;
  logic             MEM_WB_En;
  logic             IF_ID_Flush;
  logic             ID_EX_Flush;
  logic [1:0]       State;
  logic [CNT_W-1:0] Stall_Count;

  modport master (
    output ID_Rs, ID_Rt, ID_Uses_Rt, EX_MemRead, EX_RegWrite, EX_Rd,
           Branch_Taken, Mem_Busy, Halt,
    input  PC_En, IF_ID_En, ID_EX_En, EX_MEM_En, MEM_WB_En,
           IF_ID_Flush, ID_EX_Flush, State, Stall_Count
  );

  modport slave (
    input  ID_Rs, ID_Rt, ID_Uses_Rt, EX_MemRead, EX_RegWrite, EX_Rd,
           Branch_Taken, Mem_Busy, Halt,
    output PC_En, IF_ID_En, ID_EX_En, EX_MEM_En, MEM_WB_En,
           IF_ID_Flush, ID_EX_Flush, State, Stall_Count
  );
endinterface

`default_nettype wire

// File: rtl/stall_ctrl.sv
// ==== stall_ctrl: pipeline stall/flush controller (load-use, branch, memory wait, halt) ====
// ==== rev 1.0 ====
`default_nettype none

module stall_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 8
) (
  input  logic         CLK,
  input  logic         RST,
  stall_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    FLUSH    = 2'b01,
    MEM_WAIT = 2'b10,
    HALTED   = 2'b11
  } state_t;

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

  state_t           state_q, state_d;
  state_t           saved_q, saved_d;
  state_t           eval_state;
  logic [2:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             lu;
  logic             pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic             if_id_flush, id_ex_flush;

  always_comb begin
    lu = bus.EX_MemRead & bus.EX_RegWrite &
         ((bus.EX_Rd == bus.ID_Rs) | (bus.ID_Uses_Rt & (bus.EX_Rd == bus.ID_Rt)));
  end

  always_comb begin
    state_d     = state_q;
    saved_d     = saved_q;
    cnt_d       = cnt_q;
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    id_ex_en    = 1'b1;
    ex_mem_en   = 1'b1;
    mem_wb_en   = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    // The release cycle of a memory wait behaves exactly like the state it interrupted.
    eval_state  = (state_q == MEM_WAIT) ? saved_q : state_q;

    if (state_q == HALTED || bus.Mem_Busy) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
      if (state_q != HALTED && state_q != MEM_WAIT) begin
        saved_d = state_q;
        state_d = MEM_WAIT;
      end
    end else begin
      state_d = eval_state;
      if (bus.Halt) begin
        pc_en    = 1'b0;
        if_id_en = 1'b0;
        state_d  = HALTED;
      end else if (bus.Branch_Taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        if (FLUSH_CYCLES == 1) begin
          state_d = RUN;
          cnt_d   = 3'd0;
        end else begin
          state_d = FLUSH;
          cnt_d   = FLUSH_RELOAD;
        end
      end else if (eval_state == FLUSH) begin
        // ID holds a wrong-path instruction here, so a load-use match is irrelevant.
        if_id_flush = 1'b1;
        cnt_d       = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = RUN;
        end
      end else if (lu) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end
    end

    if (RST) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_en    = 1'b0;
      ex_mem_en   = 1'b0;
      mem_wb_en   = 1'b0;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_en && state_q != HALTED && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= RUN;
      saved_q     <= RUN;
      cnt_q       <= 3'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      saved_q     <= saved_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.PC_En       = pc_en;
  assign bus.IF_ID_En    = if_id_en;
  assign bus.ID_EX_En    = id_ex_en;
  assign bus.EX_MEM_En   = ex_mem_en;
  assign bus.MEM_WB_En   = mem_wb_en;
  assign bus.IF_ID_Flush = if_id_flush;
  assign bus.ID_EX_Flush = id_ex_flush;
  assign bus.State       = state_q;
  assign bus.Stall_Count = stall_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_stall_ctrl.sv
// ==== tb_stall_ctrl: directed-vector scoreboard bench for stall_ctrl ====
// ==== rev 1.0 ====
`default_nettype none

module tb_stall_ctrl;

  localparam logic [4:0] EA = 5'b11111;  // all enables
  localparam logic [4:0] ES = 5'b00111;  // PC and IF/ID held (load-use or halt)
  localparam logic [4:0] EN = 5'b00000;  // frozen
  localparam logic [1:0] S_RUN = 2'b00, S_FL = 2'b01, S_MW = 2'b10, S_HL = 2'b11;

  typedef struct packed {
    logic [31:0] idx;
    logic [12:0] exp;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  int    checks = 0;
  int    errors = 0;
  int    n = 0;
  exp_t  q[$];
  exp_t  e;
  logic [12:0] got;

  stall_ctrl_if #(.CNT_W(4)) bus();

  stall_ctrl #(.FLUSH_CYCLES(3), .CNT_W(4)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic row(input logic r, input logic [1:0] rs, input logic [1:0] rt,
                     input logic ur, input logic mr, input logic rw, input logic [1:0] rd,
                     input logic br, input logic busy, input logic hlt,
                     input logic [4:0] en, input logic [1:0] fl, input logic [1:0] st,
                     input logic [3:0] cnt);
    exp_t x;
    @(posedge clk);
    #1;
    rst              = r;
    bus.ID_Rs        = rs;
    bus.ID_Rt        = rt;
    bus.ID_Uses_Rt   = ur;
    bus.EX_MemRead   = mr;
    bus.EX_RegWrite  = rw;
    bus.EX_Rd        = rd;
    bus.Branch_Taken = br;
    bus.Mem_Busy     = busy;
    bus.Halt         = hlt;
    x.idx = n;
    x.exp = {en, fl, st, cnt};
    q.push_back(x);
    n++;
  endtask

  task automatic idle(input logic [4:0] en, input logic [1:0] fl, input logic [1:0] st,
                      input logic [3:0] cnt);
    row(1'b0, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, en, fl, st, cnt);
  endtask

  task automatic ctl(input logic r, input logic br, input logic busy, input logic hlt,
                     input logic [4:0] en, input logic [1:0] fl, input logic [1:0] st,
                     input logic [3:0] cnt);
    row(r, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0, 2'd0, br, busy, hlt, en, fl, st, cnt);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      e   = q.pop_front();
      got = {bus.PC_En, bus.IF_ID_En, bus.ID_EX_En, bus.EX_MEM_En, bus.MEM_WB_En,
             bus.IF_ID_Flush, bus.ID_EX_Flush, bus.State, bus.Stall_Count};
      checks++;
      if (got !== e.exp) begin
        errors++;
        $display("FAIL row%0d en/flush/state/count: got %b_%b_%b_%h required %b_%b_%b_%h",
                 e.idx, got[12:8], got[7:6], got[5:4], got[3:0],
                 e.exp[12:8], e.exp[7:6], e.exp[5:4], e.exp[3:0]);
      end
    end
  end

  initial begin
    bus.ID_Rs = 2'd0; bus.ID_Rt = 2'd1; bus.ID_Uses_Rt = 1'b0;
    bus.EX_MemRead = 1'b0; bus.EX_RegWrite = 1'b0; bus.EX_Rd = 2'd0;
    bus.Branch_Taken = 1'b0; bus.Mem_Busy = 1'b0; bus.Halt = 1'b0;

    // reset state
    ctl(1, 0, 0, 0, EN, 2'b00, S_RUN, 4'd0);
    ctl(1, 0, 0, 0, EN, 2'b00, S_RUN, 4'd0);
    idle(EA, 2'b00, S_RUN, 4'd0);
    // load-use via Rs, via Rt, and two near misses
    row(0, 2'd2, 2'd1, 0, 1, 1, 2'd2, 0, 0, 0, ES, 2'b01, S_RUN, 4'd0);
    idle(EA, 2'b00, S_RUN, 4'd1);
    row(0, 2'd0, 2'd3, 1, 1, 1, 2'd3, 0, 0, 0, ES, 2'b01, S_RUN, 4'd1);
    row(0, 2'd0, 2'd3, 0, 1, 1, 2'd3, 0, 0, 0, EA, 2'b00, S_RUN, 4'd2);
    row(0, 2'd2, 2'd1, 0, 0, 1, 2'd2, 0, 0, 0, EA, 2'b00, S_RUN, 4'd2);
    // branch pulse with concurrent load-use throughout the flush
    row(0, 2'd2, 2'd1, 0, 1, 1, 2'd2, 1, 0, 0, EA, 2'b11, S_RUN, 4'd2);
    row(0, 2'd2, 2'd1, 0, 1, 1, 2'd2, 0, 0, 0, EA, 2'b10, S_FL,  4'd2);
    row(0, 2'd2, 2'd1, 0, 1, 1, 2'd2, 0, 0, 0, EA, 2'b10, S_FL,  4'd2);
    idle(EA, 2'b00, S_RUN, 4'd2);
    // memory wait entered in the second flush cycle; Halt/branch ignored while busy
    ctl(0, 1, 0, 0, EA, 2'b11, S_RUN, 4'd2);
    idle(EA, 2'b10, S_FL, 4'd2);
    ctl(0, 0, 1, 0, EN, 2'b00, S_FL, 4'd2);
    ctl(0, 1, 1, 1, EN, 2'b00, S_MW, 4'd3);
    ctl(0, 0, 1, 0, EN, 2'b00, S_MW, 4'd4);
    ctl(0, 0, 1, 0, EN, 2'b00, S_MW, 4'd5);
    idle(EA, 2'b10, S_MW, 4'd6);
    idle(EA, 2'b00, S_RUN, 4'd6);
    // branch inside FLUSH reloads the counter
    ctl(0, 1, 0, 0, EA, 2'b11, S_RUN, 4'd6);
    idle(EA, 2'b10, S_FL, 4'd6);
    ctl(0, 1, 0, 0, EA, 2'b11, S_FL, 4'd6);
    idle(EA, 2'b10, S_FL, 4'd6);
    idle(EA, 2'b10, S_FL, 4'd6);
    idle(EA, 2'b00, S_RUN, 4'd6);
    // halt beats branch; HALTED is sticky and freezes the count
    ctl(0, 1, 0, 1, ES, 2'b00, S_RUN, 4'd6);
    idle(EN, 2'b00, S_HL, 4'd7);
    ctl(0, 1, 1, 0, EN, 2'b00, S_HL, 4'd7);
    ctl(1, 0, 0, 0, EN, 2'b00, S_RUN, 4'd0);
    idle(EA, 2'b00, S_RUN, 4'd0);
    // long memory wait saturates the 4-bit count
    for (int k = 0; k < 20; k++) begin
      ctl(0, 0, 1, 0, EN, 2'b00, (k == 0) ? S_RUN : S_MW, (k > 15) ? 4'd15 : 4'(k));
    end
    // reset asserted mid-wait clears everything before the next edge
    ctl(1, 0, 1, 0, EN, 2'b00, S_RUN, 4'd0);
    idle(EA, 2'b00, S_RUN, 4'd0);
    // reset mid-FLUSH discards the flush
    ctl(0, 1, 0, 0, EA, 2'b11, S_RUN, 4'd0);
    ctl(1, 0, 0, 0, EN, 2'b00, S_RUN, 4'd0);
    idle(EA, 2'b00, S_RUN, 4'd0);
    // reset mid-MEM_WAIT discards the saved FLUSH state
    ctl(0, 1, 0, 0, EA, 2'b11, S_RUN, 4'd0);
    ctl(0, 0, 1, 0, EN, 2'b00, S_FL, 4'd0);
    ctl(1, 0, 0, 0, EN, 2'b00, S_RUN, 4'd0);
    idle(EA, 2'b00, S_RUN, 4'd0);

    for (int i = 0; i < 10 && q.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d expectations left, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
